// File: rtl/sync_filter_bank.sv
// Per-channel synchronizer + glitch filter with optional edge pulses.
// Define SYNC_FILTER_BANK_EDGE_EN to enable o_rise/o_fall.
module sync_filter_bank #(
  parameter int   WIDTH     = 4,
  parameter int   STAGES    = 3,
  parameter int   FILT_LEN  = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_signal,
  output logic [WIDTH-1:0] o_signal,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

  for (genvar n = 0; n < WIDTH; n++) begin : g_ch
    logic [STAGES-1:0] chain;
    logic [CW-1:0]     cnt;
    logic              level;
    logic              sync;
    logic              load;

    assign sync = chain[STAGES-1];
    // Level flips once the disagreement has lasted FILT_LEN edges.
    assign load = (sync != level) && (cnt == LAST);

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        chain <= {STAGES{RESET_VAL}};
        cnt   <= '0;
        level <= RESET_VAL;
      end else begin
        chain <= {chain[STAGES-2:0], i_signal[n]};
        if (sync == level || load) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        if (load) begin
          level <= sync;
        end
      end
    end

    assign o_signal[n] = level;

`ifdef SYNC_FILTER_BANK_EDGE_EN
    logic rise;
    logic fall;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        rise <= 1'b0;
        fall <= 1'b0;
      end else begin
        rise <= load & sync;
        fall <= load & ~sync;
      end
    end

    assign o_rise[n] = rise;
    assign o_fall[n] = fall;
`endif
  end

`ifndef SYNC_FILTER_BANK_EDGE_EN
  assign o_rise = '0;
  assign o_fall = '0;
`endif

endmodule

// File: tb/tb_sync_filter_bank.sv
// Self-checking bench for sync_filter_bank at default parameters.
// Window-based reference model plus directed vector table and sequences.
module tb_sync_filter_bank;

  localparam int W  = 4;
  localparam int S  = 3;
  localparam int FL = 4;
  localparam bit RV = 1'b0;

`ifdef SYNC_FILTER_BANK_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sig;
  logic [W-1:0] osig;
  logic [W-1:0] orise;
  logic [W-1:0] ofall;

  int errors = 0;
  int checks = 0;

  sync_filter_bank dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_signal(sig),
    .o_signal(osig),
    .o_rise  (orise),
    .o_fall  (ofall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: delay line of inputs, window of recent sync values.
  logic [W-1:0] mpipe [S];
  logic [W-1:0] mhist [FL];
  logic [W-1:0] mout, mrise, mfall;

  task automatic model_edge(input logic r, input logic [W-1:0] d);
    logic [W-1:0] s;
    logic [W-1:0] nxt;
    bit flip;
    if (!r) begin
      for (int i = 0; i < S; i++) mpipe[i] = {W{RV}};
      for (int i = 0; i < FL; i++) mhist[i] = {W{RV}};
      mout  = {W{RV}};
      mrise = '0;
      mfall = '0;
    end else begin
      s = mpipe[S-1];
      for (int i = FL - 1; i > 0; i--) mhist[i] = mhist[i-1];
      mhist[0] = s;
      nxt = mout;
      mrise = '0;
      mfall = '0;
      for (int n = 0; n < W; n++) begin
        flip = 1'b1;
        for (int i = 0; i < FL; i++)
          if (mhist[i][n] == mout[n]) flip = 1'b0;
        if (flip) begin
          nxt[n]   = ~mout[n];
          mrise[n] = ~mout[n];
          mfall[n] = mout[n];
        end
      end
      mout = nxt;
      for (int i = S - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
      mpipe[0] = d;
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with model tracking and full output comparison.
  task automatic step(input logic r, input logic [W-1:0] d);
    rst_n = r;
    sig   = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check("model_signal", osig, mout);
    check("model_rise", orise, EDGE ? mrise : '0);
    check("model_fall", ofall, EDGE ? mfall : '0);
  endtask

  typedef struct {
    logic         r;
    logic [W-1:0] d;
    logic [W-1:0] es;
    logic [W-1:0] er;
  } vec_t;

  vec_t tbl [13];
  int   cnt;
  bit   seen;

  initial begin
    rst_n = 1'b0;
    sig   = 4'hF;
    for (int i = 0; i < S; i++) mpipe[i] = {W{RV}};
    for (int i = 0; i < FL; i++) mhist[i] = {W{RV}};
    mout = '0; mrise = '0; mfall = '0;

    // Reset with inputs high, then ch0 rises and is held.
    tbl[0] = '{1'b0, 4'hF, 4'h0, 4'h0};
    tbl[1] = '{1'b0, 4'hF, 4'h0, 4'h0};
    for (int i = 2; i < 13; i++) begin
      tbl[i].r  = 1'b1;
      tbl[i].d  = 4'h1;
      tbl[i].es = (i - 1 >= S + FL) ? 4'h1 : 4'h0;
      tbl[i].er = (i - 1 == S + FL && EDGE) ? 4'h1 : 4'h0;
    end
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].d);
      check($sformatf("tbl%0d_signal", i), osig, tbl[i].es);
      check($sformatf("tbl%0d_rise", i), orise, tbl[i].er);
      check($sformatf("tbl%0d_fall", i), ofall, 4'h0);
    end

    // Glitch: ch1 high for 3 cycles only.
    for (int i = 0; i < 3; i++) step(1'b1, 4'h3);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'h1);
      check("glitch_signal1", {3'b0, osig[1]}, 4'h0);
      check("glitch_rise1", {3'b0, orise[1]}, 4'h0);
    end

    // Independence: ch3 up first, then ch2 up and ch3 down together.
    for (int i = 0; i < 12; i++) step(1'b1, 4'h9);
    check("indep_pre", osig, 4'h9);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, 4'h5);
      if (osig[2]) begin
        seen = 1'b1;
        check("indep_signal", osig, 4'h5);
        check("indep_rise", orise, EDGE ? 4'h4 : 4'h0);
        check("indep_fall", ofall, EDGE ? 4'h8 : 4'h0);
      end
    end
    check("indep_timeout", {3'b0, seen}, 4'h1);

    // Mid-operation reset: reset at the 5th edge discards pending count.
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h1);
    step(1'b0, 4'h1);
    check("midrst_signal", osig, 4'h0);
    check("midrst_pulse", orise | ofall, 4'h0);
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, 4'h1);
      cnt++;
      if (osig[0]) begin
        seen = 1'b1;
        check("midrst_rise", orise, EDGE ? 4'h1 : 4'h0);
      end
    end
    check("midrst_latency", 4'(cnt), 4'(S + FL));

    // Random stimulus, slow-changing, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) sig = sig ^ W'(1 << $urandom_range(W - 1, 0));
      step(($urandom_range(79, 0) != 0), sig);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_filter_bank.md
SYNC_FILTER_BANK -- requirements
Module: sync_filter_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, number of independent asynchronous input channels (1..32).
REQ-002 SHALL provide parameter STAGES, default 3, synchronizer flip-flop depth per channel (2..4).
REQ-003 SHALL provide parameter FILT_LEN, default 4, consecutive stable cycles required before an output change (1..255).
REQ-004 SHALL provide parameter RESET_VAL, default 1'b0, value loaded into every chain stage and output bit at reset.
REQ-005 SHALL provide port i_clk  input  1  system clock, sole clock of the block.
REQ-006 SHALL provide port i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL provide port i_signal  input  WIDTH  asynchronous input signals, one bit per channel.
REQ-008 SHALL provide port o_signal  output  WIDTH  synchronized, glitch-filtered level per channel.
REQ-009 SHALL provide port o_rise  output  WIDTH  one-cycle pulse per channel on a filtered 0->1 transition.
REQ-010 SHALL provide port o_fall  output  WIDTH  one-cycle pulse per channel on a filtered 1->0 transition.

Function
REQ-011 Each channel SHALL be fully independent; no logic shared across channels except i_clk/i_rst_n.
REQ-012 Each channel SHALL sample i_signal[n] into a STAGES-deep shift chain on every rising i_clk edge; the last stage is the synchronized bit sync[n].
REQ-013 Each channel SHALL hold a counter of width $clog2(FILT_LEN+1) that increments on every edge where sync[n] differs from o_signal[n].
REQ-014 The counter SHALL clear to 0 on any edge where sync[n] equals o_signal[n] (glitch shorter than FILT_LEN cycles discarded).
REQ-015 When the counter equals FILT_LEN-1 and sync[n] still differs from o_signal[n], the next edge SHALL load o_signal[n] <= sync[n] and clear the counter.
REQ-016 FILT_LEN=1 SHALL degenerate to one extra register stage (output follows sync[n] one edge later, no filtering).
REQ-017 Latency: an input level held stable SHALL appear on o_signal exactly STAGES+FILT_LEN rising edges after the first edge sampling it (7 at defaults).
REQ-018 o_rise[n]/o_fall[n] SHALL be registered and asserted high for exactly one cycle, in the same cycle o_signal[n] first shows the new level.
REQ-019 o_rise[n] and o_fall[n] SHALL never be high simultaneously; consecutive pulses on one channel SHALL be separated by at least FILT_LEN cycles.
REQ-020 The counter SHALL never exceed FILT_LEN-1 (no wrap-around possible).
REQ-021 A pulse on i_signal[n] lasting fewer than FILT_LEN cycles after synchronization SHALL produce no change on o_signal[n], o_rise[n] or o_fall[n].

Reset
REQ-022 On any rising i_clk edge with i_rst_n low, all chain stages and o_signal SHALL load RESET_VAL per bit, counters 0, o_rise/o_fall 0.
REQ-023 Reset asserted mid-filtering SHALL discard pending counts; no edge pulse SHALL be generated by reset itself.
REQ-024 The first edge with i_rst_n high SHALL sample i_signal normally; latency per REQ-017 applies from that edge.

Configuration
REQ-025 Macro SYNC_FILTER_BANK_EDGE_EN SHALL control edge detection.
REQ-026 With SYNC_FILTER_BANK_EDGE_EN defined, o_rise/o_fall SHALL behave per REQ-018..019.
REQ-027 Without it, o_rise/o_fall SHALL be tied constant 0, no edge registers inferred; o_signal behaviour unchanged.

Verification
REQ-028 Reset: i_rst_n=0 for 2 edges, RESET_VAL=0, i_signal=4'hF -> o_signal=4'h0, o_rise=o_fall=0 throughout reset.
REQ-029 Latency: defaults, i_signal[0] 0->1 held -> o_signal[0]=1 and o_rise[0]=1 for one cycle exactly 7 edges after first sampling edge.
REQ-030 Glitch: defaults, i_signal[1] high for 3 cycles then low -> o_signal[1] stays 0, no o_rise[1].
REQ-031 Independence: channels 2 and 3 toggle in same cycle, opposite directions -> o_rise[2] and o_fall[3] in same cycle, other channels quiet.
REQ-032 Mid-op reset: i_signal[0]=1 held, i_rst_n=0 at edge 5 (counter nonzero) -> o_signal[0]=0, no pulse; after release, rise after 7 further edges.
REQ-033 Macro off: repeat REQ-029 without SYNC_FILTER_BANK_EDGE_EN -> o_signal identical, o_rise/o_fall constantly 0.
